mem_stage_lsu: RTL

- Parametrised successor to the pipelined MIPS memory stage: data RAM plus the MEM1→ME pipeline register.
- Supports byte, halfword and word loads and stores, signed or unsigned load extension, and per-lane byte-enable writes.
- Loads and stores that cross a word boundary are split into two beats by a small FSM, which stalls the front end for one cycle.
- Adds parametrised RAM depth and configurable-width retire/cycle performance counters. Sits between EX and writeback.

---
 rtl/mem_stage_lsu.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// MEM stage load/store unit: data RAM, split handling for word-crossing accesses,
// the MEM1->ME pipeline register and retire/cycle performance counters.
module mem_stage_lsu #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned CNT_W       = 16,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             AnyStall,
    input  logic [31:0]      Result_EX,
    input  logic [31:0]      WrDat_EX,
    input  logic             RegWrite_EX,
    input  logic             MemToReg_EX,
    input  logic             MemWrite_EX,
    input  logic [1:0]       Size_EX,
    input  logic             Unsigned_EX,
    input  logic [4:0]       WriteReg_EX,
    input  logic             InstrVal_EX,
    output logic [31:0]      RdDat_ME,
    output logic [31:0]      Result_ME,
    output logic [31:0]      ResultRdDat_ME,
    output logic [4:0]       WriteReg_ME,
    output logic             RegWrite_ME,
    output logic             MemToReg_ME,
    output logic             MisAlignStall_MEM1,
    output logic [CNT_W-1:0] Cycles_ME,
    output logic [CNT_W-1:0] Instr_ME
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, SECOND} state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [31:0]       hold_q;
    logic [31:0]       rddat_q, result_q, resrd_q;
    logic [4:0]        wreg_q;
    logic              rw_q, m2r_q;
    logic [CNT_W-1:0]  cycles_q, instr_q;

    logic [31:0]       eff_addr;
    logic [1:0]        off;
    logic [3:0]        nbytes, base_mask;
    logic              spans;
    logic [AW-1:0]     idx_a, idx_b, idx;
    logic [5:0]        lsh, rsh;
    logic [31:0]       rd_word, raw_a, ld_raw, ld_data;
    logic [3:0]        we_mask;
    logic [31:0]       wr_word;
    logic              do_write;
    logic              split_first;
    logic              instr_inc;
    logic              unused_addr;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sz,
                                           input logic uns);
        case (sz)
            2'b00:   return {{24{~uns & raw[7]}}, raw[7:0]};
            2'b01:   return {{16{~uns & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // Address decode, span detection and lane/data alignment for both beats
    always_comb begin
        eff_addr = Result_EX;
        if (!MISALIGN_EN) begin
            case (Size_EX)
                2'b00:   eff_addr = Result_EX;
                2'b01:   eff_addr[0] = 1'b0;
                default: eff_addr[1:0] = 2'b00;
            endcase
        end
        off = eff_addr[1:0];
        case (Size_EX)
            2'b00:   begin nbytes = 4'd1; base_mask = 4'b0001; end
            2'b01:   begin nbytes = 4'd2; base_mask = 4'b0011; end
            default: begin nbytes = 4'd4; base_mask = 4'b1111; end
        endcase
        spans = MISALIGN_EN && ((4'({2'b00, off}) + nbytes) > 4'd4)
                && (MemToReg_EX || MemWrite_EX);

        idx_a = eff_addr[AW+1:2];
        idx_b = idx_a + AW'(1);
        idx   = (state_q == SECOND) ? idx_b : idx_a;
        lsh   = {1'b0, off, 3'b000};
        rsh   = 6'd32 - lsh;

        rd_word = mem_q[idx];
        raw_a   = rd_word >> lsh;
        ld_raw  = (state_q == SECOND) ? (hold_q | (rd_word << rsh)) : raw_a;
        ld_data = extend(ld_raw, Size_EX, Unsigned_EX);

        if (state_q == SECOND) begin
            we_mask = base_mask >> (3'd4 - {1'b0, off});
            wr_word = WrDat_EX >> rsh;
        end else if (spans) begin
            we_mask = 4'hF << off;
            wr_word = WrDat_EX << lsh;
        end else begin
            we_mask = base_mask << off;
            wr_word = WrDat_EX << lsh;
        end
        do_write = MemWrite_EX && !AnyStall && !flush;
    end

    assign split_first        = (state_q == IDLE) && spans;
    assign MisAlignStall_MEM1 = split_first && !AnyStall;
    assign instr_inc          = InstrVal_EX && !AnyStall && !flush && !MisAlignStall_MEM1;
    assign unused_addr        = ^{eff_addr[31:AW+2]};

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else if (!AnyStall) begin
            if (split_first)             state_d = SECOND;
            else if (state_q == SECOND)  state_d = IDLE;
        end
    end

    // Data RAM: byte-lane writes, contents not reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (we_mask[k]) mem_q[idx][8*k +: 8] <= wr_word[8*k +: 8];
            end
        end
    end

    // Pipeline register, hold register, FSM state and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            rddat_q  <= '0;
            result_q <= '0;
            resrd_q  <= '0;
            wreg_q   <= '0;
            rw_q     <= 1'b0;
            m2r_q    <= 1'b0;
            cycles_q <= '0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_q + CNT_W'(1);
            if (instr_inc) instr_q <= instr_q + CNT_W'(1);
            if (flush) begin
                rw_q    <= 1'b0;
                m2r_q   <= 1'b0;
                wreg_q  <= '0;
                resrd_q <= result_q;
            end else if (!AnyStall) begin
                if (split_first) begin
                    rw_q    <= 1'b0;
                    m2r_q   <= 1'b0;
                    resrd_q <= result_q;
                    hold_q  <= raw_a;
                end else begin
                    rw_q     <= RegWrite_EX;
                    m2r_q    <= MemToReg_EX;
                    wreg_q   <= WriteReg_EX;
                    result_q <= Result_EX;
                    rddat_q  <= ld_data;
                    resrd_q  <= MemToReg_EX ? ld_data : Result_EX;
                end
            end
        end
    end

    assign RdDat_ME       = rddat_q;
    assign Result_ME      = result_q;
    assign ResultRdDat_ME = resrd_q;
    assign WriteReg_ME    = wreg_q;
    assign RegWrite_ME    = rw_q;
    assign MemToReg_ME    = m2r_q;
    assign Cycles_ME      = cycles_q;
    assign Instr_ME       = instr_q;

endmodule
